// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched
// Round-robin scheduler that shares one RemoteComm link (16-bit command out,
// 8-bit response in) among NUM_REQ requesters. A granted command is latched,
// sent with a one-cycle snd_cmd pulse, and the response byte (or a timeout)
// is returned to the owning requester with a one-cycle done pulse.
//
// Optional feature: define REMOTE_RETRY_EN to resend a command whose response
// is not ACK_BYTE, up to MAX_RETRY times, before reporting it.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, req_cmd    per-requester request level and 16-bit command slices
//   gnt             one-hot grant pulse
//   busy            high from grant until the transaction finishes
//   done            one-cycle completion pulse with done_id/done_resp/tmo_err
//   snd_cmd, cmd    send pulse and latched command toward RemoteComm
//   cmd_snt         RemoteComm: command bytes sent (level)
//   resp_rdy, resp  RemoteComm: response ready level and response byte
module remote_cmd_sched #(
    parameter int         NUM_REQ    = 4,
    parameter int         TMO_CYCLES = 1_000_000,
    parameter logic [7:0] ACK_BYTE   = 8'hA5,
    parameter int         MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_cmd,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic [7:0]             done_resp,
    output logic                   tmo_err,
    output logic                   snd_cmd,
    output logic [15:0]            cmd,
    input  logic                   cmd_snt,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp
);

    localparam int TW = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr;
    logic [TW-1:0] timer;
    logic          rdy_q;
    logic          rdy_edge, tmo_hit;
    logic          take_resp, take_tmo;
    logic          grant_vld;
    logic [2:0]    grant_idx;
    logic [2:0]    cand;
    logic [7:0]    req8;
    logic [15:0]   cmd_sel;

`ifdef REMOTE_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
    logic          retry_now;
`endif

    assign req8     = 8'(req);
    assign rdy_edge = resp_rdy & ~rdy_q;
    assign tmo_hit  = (timer == TW'(TMO_CYCLES - 1));

    // Round-robin pick: first requester set, searching upward from ptr+1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        cand      = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((int'(ptr) + k) % NUM_REQ);
            if (!grant_vld && req8[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Command slice of the requester about to be granted.
    always_comb begin
        cmd_sel = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                cmd_sel = req_cmd[16*i +: 16];
            end
        end
    end

    // Next-state logic; a response edge always beats a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        take_resp = 1'b0;
        take_tmo  = 1'b0;
`ifdef REMOTE_RETRY_EN
        retry_now = 1'b0;
`endif
        case (state_q)
            IDLE:     if (grant_vld) state_d = SEND;
            SEND:     state_d = WAIT_SNT;
            WAIT_SNT, WAIT_RESP: begin
                if (rdy_edge) begin
`ifdef REMOTE_RETRY_EN
                    if (resp != ACK_BYTE && retry_cnt < RW'(MAX_RETRY)) begin
                        retry_now = 1'b1;
                        state_d   = SEND;
                    end else begin
                        take_resp = 1'b1;
                        state_d   = DONE;
                    end
`else
                    take_resp = 1'b1;
                    state_d   = DONE;
`endif
                end else if (tmo_hit) begin
                    take_tmo = 1'b1;
                    state_d  = DONE;
                end else if (state_q == WAIT_SNT && cmd_snt) begin
                    state_d = WAIT_RESP;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs; the timer saturates at expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 3'd0;
            done_resp <= 8'h00;
            tmo_err   <= 1'b0;
            snd_cmd   <= 1'b0;
            cmd       <= 16'h0000;
            ptr       <= 3'(NUM_REQ - 1);
            timer     <= '0;
            rdy_q     <= 1'b0;
`ifdef REMOTE_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            rdy_q   <= resp_rdy;
            gnt     <= '0;
            snd_cmd <= (state_q == SEND);
            done    <= take_resp | take_tmo;
            tmo_err <= take_tmo;
            if (state_q == IDLE && grant_vld) begin
                gnt  <= NUM_REQ'(1) << grant_idx;
                cmd  <= cmd_sel;
                ptr  <= grant_idx;
                busy <= 1'b1;
`ifdef REMOTE_RETRY_EN
                retry_cnt <= '0;
`endif
            end
            if (state_q == DONE) busy <= 1'b0;
            if (take_resp) begin
                done_resp <= resp;
                done_id   <= ptr;
            end else if (take_tmo) begin
                done_resp <= 8'h00;
                done_id   <= ptr;
            end
            if (state_q == SEND) begin
                timer <= '0;
            end else if ((state_q == WAIT_SNT || state_q == WAIT_RESP) && !tmo_hit) begin
                timer <= timer + 1'b1;
            end
`ifdef REMOTE_RETRY_EN
            if (retry_now) retry_cnt <= retry_cnt + 1'b1;
`endif
        end
    end

endmodule
